// File: rtl/seg_scan_ctrl_if.sv
// Display-controller bus for seg_scan_ctrl: load/strobe side plus the
// decoder and anode drive side, grouped so they travel together.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      enable;
   logic                      lzb;
   logic                      load;
   logic [3*NUM_DIGITS-1:0]   load_value;
   logic                      load_ack;
   logic [2:0]                dec_code;
   logic                      dec_en;
   logic [NUM_DIGITS-1:0]     an;

   modport master (
      output enable, lzb, load, load_value,
      input  load_ack, dec_code, dec_en, an
   );

   modport slave (
      input  enable, lzb, load, load_value,
      output load_ack, dec_code, dec_en, an
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller driving one shared seven-segment decoder
// across NUM_DIGITS digits, with frame-synchronous double-buffered updates.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 1000,
   parameter int SHOW_TICKS = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_ctrl_if.slave bus
);
   localparam int W  = 3 * NUM_DIGITS;
   localparam int CW = $clog2(TICK_DIV);
   localparam int SW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    disp_reg, disp_next;
   logic [W-1:0]    shadow_reg;
   logic            pend_reg;
   logic [IW-1:0]   idx_reg, idx_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [SW-1:0]   scnt_reg, scnt_next;
   logic            tick;
   logic            xfer;

   logic [NUM_DIGITS-1:0] blank_next;
   logic [2:0]            digit_next [NUM_DIGITS];

   genvar gi;

   // Digit i is blanked when it and every more significant digit are zero.
   assign blank_next[0] = 1'b0;
   generate
      for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
         assign blank_next[gi] = bus.lzb && (disp_next[W-1:3*gi] == '0);
      end
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign digit_next[gi] = disp_next[3*gi +: 3];
      end
   endgenerate

   assign tick = (cnt_reg == CW'(TICK_DIV - 1));

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      scnt_next  = scnt_reg;
      xfer       = 1'b0;
      if (!bus.enable) begin
         state_next = OFF;
         idx_next   = '0;
         cnt_next   = '0;
         scnt_next  = '0;
         xfer       = (state_reg == OFF) && pend_reg;
      end else begin
         case (state_reg)
            OFF: begin
               state_next = BLANK;
               idx_next   = '0;
               cnt_next   = '0;
               xfer       = pend_reg;
            end
            BLANK: begin
               cnt_next = tick ? '0 : cnt_reg + CW'(1);
               if (tick) begin
                  state_next = SHOW;
                  scnt_next  = '0;
               end
            end
            SHOW: begin
               cnt_next = tick ? '0 : cnt_reg + CW'(1);
               if (tick) begin
                  if (scnt_reg == SW'(SHOW_TICKS - 1)) begin
                     state_next = BLANK;
                     idx_next   = (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + IW'(1);
                     // Leaving the last digit's slot is the frame boundary.
                     xfer       = pend_reg && (idx_reg == IW'(NUM_DIGITS - 1));
                  end else begin
                     scnt_next = scnt_reg + SW'(1);
                  end
               end
            end
            default: begin
               state_next = OFF;
            end
         endcase
      end
      disp_next = xfer ? shadow_reg : disp_reg;
   end

   // Outputs are registered from next-state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= OFF;
         disp_reg     <= '0;
         shadow_reg   <= '0;
         pend_reg     <= 1'b0;
         idx_reg      <= '0;
         cnt_reg      <= '0;
         scnt_reg     <= '0;
         bus.load_ack <= 1'b0;
         bus.dec_code <= 3'd0;
         bus.dec_en   <= 1'b0;
         bus.an       <= '0;
      end else begin
         state_reg    <= state_next;
         disp_reg     <= disp_next;
         idx_reg      <= idx_next;
         cnt_reg      <= cnt_next;
         scnt_reg     <= scnt_next;
         // A strobe on a transfer edge restages rather than being lost.
         if (bus.load) begin
            shadow_reg <= bus.load_value;
         end
         pend_reg     <= bus.load || (pend_reg && !xfer);
         bus.load_ack <= xfer;
         if (state_next == SHOW) begin
            bus.an       <= NUM_DIGITS'(1) << idx_next;
            bus.dec_code <= digit_next[idx_next];
            bus.dec_en   <= !blank_next[idx_next];
         end else begin
            bus.an       <= '0;
            bus.dec_code <= 3'd0;
            bus.dec_en   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random loads/toggles,
// checked every cycle against a timeline model of the scan.
module tb_seg_scan_ctrl;
   localparam int ND    = 4;
   localparam int TD    = 4;
   localparam int ST    = 3;
   localparam int SLOT  = (1 + ST) * TD;
   localparam int FRAME = ND * SLOT;

   logic clk;
   logic rst_n;

   seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS(ND),
      .TICK_DIV  (TD),
      .SHOW_TICKS(ST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: m_t counts cycles since BLANK entry; slot/digit follow from it.
   bit m_on;
   int m_t;
   int m_disp;
   int m_shadow;
   bit m_pend;
   bit m_ack;
   bit m_lzb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_on = 0; m_t = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_ack = 0;
   endtask

   task automatic step();
      bit en, ld, xfer;
      int lv, pos, dig, dval, exp_an, exp_en, exp_code;
      @(posedge clk);
      en = bus.enable; ld = bus.load; lv = int'(bus.load_value); m_lzb = bus.lzb;
      xfer = 0;
      if (m_on) begin
         if (en) begin
            if ((m_t % FRAME) == FRAME - 1 && m_pend) xfer = 1;
            m_t++;
         end else begin
            m_on = 0;
         end
      end else begin
         if (m_pend) xfer = 1;
         if (en) begin m_on = 1; m_t = 0; end
      end
      if (xfer) begin m_disp = m_shadow; m_pend = 0; end
      if (ld) begin m_shadow = lv; m_pend = 1; end
      m_ack = xfer;
      #1;
      exp_an = 0; exp_en = 0; exp_code = 0;
      if (m_on) begin
         pos = m_t % SLOT;
         dig = (m_t / SLOT) % ND;
         if (pos >= TD) begin
            dval     = (m_disp >> (3 * dig)) & 7;
            exp_an   = 1 << dig;
            exp_code = dval;
            exp_en   = (m_lzb && dig >= 1 && (m_disp >> (3 * dig)) == 0) ? 0 : 1;
         end
      end
      chk("an", 32'(bus.an), 32'(exp_an));
      chk("dec_en", 32'(bus.dec_en), 32'(exp_en));
      chk("dec_code", 32'(bus.dec_code), 32'(exp_code));
      chk("load_ack", 32'(bus.load_ack), 32'(m_ack));
      chk("an_onehot0", 32'($countones(bus.an) <= 1), 32'd1);
      if (m_ack) $display("ack  t=%0t disp=0x%03h", $time, m_disp);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input int v);
      bus.load = 1'b1;
      bus.load_value = 12'(v);
      $display("load t=%0t value=0x%03h", $time, v);
      step();
      bus.load = 1'b0;
   endtask

   task automatic run_to_digit(input int d);
      int n = 0;
      while (!(m_on && ((m_t / SLOT) % ND) == d && (m_t % SLOT) >= TD) && n < 200) begin
         step();
         n++;
      end
      chk("wait_digit_lit", 32'(n < 200), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      bus.enable = 1'b0; bus.lzb = 1'b0; bus.load = 1'b0; bus.load_value = '0;
      model_reset();
      #2;
      chk("rst_an", 32'(bus.an), 32'd0);
      chk("rst_dec_en", 32'(bus.dec_en), 32'd0);
      chk("rst_dec_code", 32'(bus.dec_code), 32'd0);
      chk("rst_load_ack", 32'(bus.load_ack), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      run(3);

      // Load while off, then enable: ack two cycles after the strobe edge.
      do_load(12'h3A5);
      bus.enable = 1'b1;
      step();
      chk("off_load_ack", 32'(bus.load_ack), 32'd1);
      run(2 * FRAME);

      // Two loads mid-frame: last wins, one ack at the boundary.
      run_to_digit(1);
      do_load(1);
      run(5);
      do_load(2);
      run(FRAME + 10);

      // Strobe exactly on the boundary edge with pend set.
      run_to_digit(1);
      do_load(7);
      n = 0;
      while ((m_t % FRAME) != FRAME - 1 && n < 200) begin step(); n++; end
      chk("wait_boundary", 32'(n < 200), 32'd1);
      bus.load = 1'b1; bus.load_value = 12'h123;
      $display("load t=%0t value=0x123 (boundary edge)", $time);
      step();
      bus.load = 1'b0;
      chk("boundary_ack_old", 32'(bus.load_ack), 32'd1);
      run(FRAME + 10);

      // Leading-zero blanking.
      do_load(0);
      run(FRAME + 4);
      bus.lzb = 1'b1;
      run(FRAME);
      do_load(12'h040);
      run(2 * FRAME);

      // Enable dropped during digit 2, then restored.
      run_to_digit(2);
      bus.enable = 1'b0;
      step();
      chk("disable_an", 32'(bus.an), 32'd0);
      run(5);
      bus.enable = 1'b1;
      run(FRAME + 4);

      // Asynchronous reset mid-SHOW.
      run_to_digit(1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_an", 32'(bus.an), 32'd0);
      chk("midrst_dec_en", 32'(bus.dec_en), 32'd0);
      chk("midrst_load_ack", 32'(bus.load_ack), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      n = 0;
      while (bus.an == '0 && n < 50) begin step(); n++; end
      chk("restart_latency", 32'(n), 32'(1 + TD));
      run(FRAME);

      // Random loads, blanking toggles and enable drops.
      for (int i = 0; i < 1200; i++) begin
         bus.load = ($urandom_range(0, 15) == 0);
         bus.load_value = 12'($urandom_range(0, 4095));
         if (bus.load) $display("load t=%0t value=0x%03h", $time, bus.load_value);
         if ($urandom_range(0, 99) == 0) bus.lzb = ~bus.lzb;
         if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
         step();
      end
      bus.load = 1'b0;
      bus.enable = 1'b1;
      run(2 * FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the shared 3-bit seven-segment decoder. Holds a NUM_DIGITS-digit display word and steps one decoder across the digits, one at a time. For each digit it drives the decoder's code/enable inputs together with a one-hot digit-select output. Display updates are double-buffered and applied only at frame boundaries, so a digit never shows a mix of old and new values. Sits between the register/control logic that produces display values and the decoder plus anode drivers.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- TICK_DIV, 1000: clk cycles per scan tick (>=2).
- SHOW_TICKS, 3: ticks a digit is lit per slot (>=1).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scanning; 0 = display off.
- lzb  in  1  leading-zero blanking enable.
- load  in  1  single-cycle strobe; captures load_value.
- load_value  in  3*NUM_DIGITS  digit i at bits [3i+2:3i]; digit 0 is least significant.
- load_ack  out  1  one-cycle pulse when a loaded value becomes the displayed value.
- dec_code  out  3  digit code to decoder {a,b,c}; a = bit 2.
- dec_en  out  1  decoder enable.
- an  out  NUM_DIGITS  one-hot active-high digit select.

## Operation
- Registers: disp (displayed word), shadow (staged word), pend flag, state, digit index idx, prescaler cnt, show counter scnt.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Prescaler: held at 0 in OFF. In any other state it counts 0..TICK_DIV-1 and wraps. tick = (cnt == TICK_DIV-1).
- FSM states and transitions:
  - OFF: an=0, dec_en=0, idx=0.
    - enable=1 -> BLANK, with cnt=0 and idx=0.
  - BLANK: an=0, dec_en=0. Anti-ghosting gap of one tick.
    - tick -> SHOW, with scnt=0.
  - SHOW: an=onehot(idx), dec_code=disp[idx], dec_en=1 unless the digit is blanked.
    - tick with scnt<SHOW_TICKS-1 -> scnt+1, stay in SHOW.
    - tick with scnt=SHOW_TICKS-1 -> BLANK, with idx=(idx+1) mod NUM_DIGITS.
  - From any state, enable=0 -> OFF on the next edge. Takes priority over every other transition. disp, shadow and pend are retained.
- Scan order: digit 0 first, up to digit NUM_DIGITS-1, then wrap to 0.
- Load:
  - A load strobe writes shadow <= load_value and sets pend.
  - Several loads before a transfer: the last value wins, and exactly one load_ack is issued.
- Frame boundary: the edge leaving SHOW of digit NUM_DIGITS-1.
  - If pend=1 on that edge: disp <= shadow, pend cleared, load_ack=1 for the following cycle.
- In OFF with pend=1: transfer on the next edge, same ack rule.
- Load coincident with a transfer edge: the transfer uses the pre-edge shadow. The new value is written to shadow and pend stays set, so it applies at the next boundary.
- Leading-zero blanking: with lzb=1, digit i (i>=1) is blanked when digits NUM_DIGITS-1..i of disp are all zero.
  - A blanked digit has an asserted but dec_en=0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Reset (rst_n=0, asynchronous):
  - state=OFF; disp, shadow, pend, cnt, scnt, idx = 0.
  - All outputs 0: load_ack=0, dec_code=0, dec_en=0, an=0.
  - Reset during a scan aborts the scan immediately. Scanning restarts from digit 0 after release if enable=1.

## Timing
- Enable sampled high at edge k: BLANK from k+1. First SHOW of digit 0 starts TICK_DIV cycles after entering BLANK.
- Slot length = (1+SHOW_TICKS)*TICK_DIV cycles: BLANK for TICK_DIV, lit for SHOW_TICKS*TICK_DIV.
- Frame length = NUM_DIGITS*(1+SHOW_TICKS)*TICK_DIV cycles.
- an is never multi-hot. an and dec_code change only on BLANK/SHOW edges, never mid-slot.
- Load-to-display latency: at most one frame plus one cycle while scanning; exactly 2 cycles in OFF (strobe edge, then transfer edge).
- enable falling: an=0 and dec_en=0 one cycle after the sampled low.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=4, SHOW_TICKS=3 (slot 16 cycles, frame 64 cycles).

- Reset mid-SHOW (rst_n low for 1 cycle) -> an=0, dec_en=0, load_ack=0 immediately. After release with enable=1, digit 0 lit exactly 4 cycles after BLANK entry.
- enable=1, load 0x3A5 (digits 5,4,6,1 for digits 0..3) while OFF -> load_ack 2 cycles later. Digits 0..3 then scan with dec_code 5,4,6,1, each lit 12 cycles after a 4-cycle gap, with an = 0001, 0010, 0100, 1000.
- While scanning, load 1 then load 2 mid-frame -> display unchanged until the frame boundary. Then value 2 is displayed and a single load_ack is issued. an is never multi-hot and never changes mid-slot.
- Load strobe on the exact boundary edge with pend=1 -> old shadow displayed and acked. The new value is applied with a second ack 64 cycles later.
- lzb=1, disp=0 -> only digit 0 has dec_en=1 (code 0); digits 1-3 have an asserted and dec_en=0. disp=0x040 -> digits 0-2 enabled, digit 3 blanked.
- enable dropped during digit 2 -> OFF next cycle with an=0. enable raised again -> scan restarts at digit 0 and disp is retained.
